// File: rtl/lag_integrator.sv
// Two-stage lag integrator: scaled error register, clamped accumulator and a limit-to-limit sweep FSM.
// Optional clamp-event counter enabled by defining LAG_HIT_COUNT_EN.
module lag_integrator #(
    parameter int ERR_W = 8,
    parameter int ACC_W = 32,
    parameter int EXP_W = 5
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clkEn,
    input  logic             clear,
    input  logic             hold,
    input  logic [ERR_W-1:0] error,
    input  logic [EXP_W-1:0] lagExp,
    input  logic [ACC_W-1:0] limit,
    input  logic             sweepEn,
    input  logic [ACC_W-1:0] sweepOffsetMag,
    output logic [ACC_W-1:0] lagAccum,
    output logic [1:0]       sweepState,
    output logic             atUpper,
    output logic             atLower,
    output logic [15:0]      limitHits
);

    localparam int TRUNC_W = 1 << EXP_W;
    localparam int SH_W    = ERR_W + TRUNC_W - 1;
    localparam int SUM_W   = ACC_W + 2;

    localparam logic [1:0] TRACK      = 2'b00;
    localparam logic [1:0] SWEEP_UP   = 2'b01;
    localparam logic [1:0] SWEEP_DOWN = 2'b10;

    localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};

    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    // Assert asynchronously, release two clocks after resetN rises.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    logic signed [SH_W-1:0]    err_wide;
    logic signed [SH_W-1:0]    err_shl;
    logic signed [TRUNC_W-1:0] err_trunc;
    logic signed [ACC_W-1:0]   lag_err_d;
    logic signed [ACC_W-1:0]   lag_err_q;

    // Shift in a field wide enough for the largest exponent so no bits are lost.
    always_comb begin
        err_wide  = SH_W'(signed'(error));
        err_shl   = err_wide <<< lagExp;
        err_trunc = TRUNC_W'(err_shl >>> (ERR_W - 1));
        lag_err_d = (lagExp == '0) ? '0 : ACC_W'(err_trunc);
    end

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W:0]   offset_q, offset_d;
    logic signed [ACC_W:0]   mag_pos;
    logic [1:0]              state_q, state_d;
    logic                    at_upper_q, at_lower_q;
    logic [ACC_W-1:0]        lim_c;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] ul;
    logic signed [SUM_W-1:0] ll;
    logic                    clamp_hi, clamp_lo;

    always_comb begin
        lim_c = (limit > MAX_POS) ? MAX_POS : limit;
        ul    = signed'(SUM_W'(lim_c));
        ll    = -ul;
        sum   = SUM_W'(acc_q) + SUM_W'(lag_err_q) + SUM_W'(offset_q);
        // With a zero limit a zero sum is in range, not a clamp.
        clamp_hi = (sum > ul) || ((sum == ul) && (lim_c != '0));
        clamp_lo = !clamp_hi && ((sum < ll) || ((sum == ll) && (lim_c != '0)));
        if (clamp_hi) begin
            acc_d = ACC_W'(ul);
        end else if (clamp_lo) begin
            acc_d = ACC_W'(ll);
        end else begin
            acc_d = ACC_W'(sum);
        end
    end

    always_comb begin
        mag_pos  = signed'({1'b0, sweepOffsetMag});
        state_d  = state_q;
        offset_d = offset_q;
        if (!sweepEn) begin
            state_d  = TRACK;
            offset_d = '0;
        end else begin
            case (state_q)
                TRACK: begin
                    state_d  = SWEEP_UP;
                    offset_d = mag_pos;
                end
                SWEEP_UP: begin
                    if (clamp_hi) begin
                        state_d  = SWEEP_DOWN;
                        offset_d = -mag_pos;
                    end
                end
                SWEEP_DOWN: begin
                    if (clamp_lo) begin
                        state_d  = SWEEP_UP;
                        offset_d = mag_pos;
                    end
                end
                default: begin
                    state_d  = TRACK;
                    offset_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lag_err_q  <= '0;
            acc_q      <= '0;
            offset_q   <= '0;
            state_q    <= TRACK;
            at_upper_q <= 1'b0;
            at_lower_q <= 1'b0;
        end else if (clkEn) begin
            if (clear) begin
                lag_err_q  <= '0;
                acc_q      <= '0;
                offset_q   <= '0;
                state_q    <= TRACK;
                at_upper_q <= 1'b0;
                at_lower_q <= 1'b0;
            end else begin
                lag_err_q <= lag_err_d;
                if (!hold) begin
                    acc_q      <= acc_d;
                    offset_q   <= offset_d;
                    state_q    <= state_d;
                    at_upper_q <= clamp_hi;
                    at_lower_q <= clamp_lo;
                end
            end
        end
    end

`ifdef LAG_HIT_COUNT_EN
    logic [15:0] hits_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            hits_q <= '0;
        end else if (clkEn) begin
            if (clear) begin
                hits_q <= '0;
            end else if (!hold && (clamp_hi || clamp_lo) && (hits_q != '1)) begin
                hits_q <= hits_q + 16'd1;
            end
        end
    end

    assign limitHits = hits_q;
`else
    assign limitHits = '0;
`endif

    assign lagAccum   = acc_q;
    assign sweepState = state_q;
    assign atUpper    = at_upper_q;
    assign atLower    = at_lower_q;

endmodule

// File: tb/tb_lag_integrator.sv
// Self-checking bench for lag_integrator: directed literal checks plus randomized run against an arithmetic model.
`timescale 1ns/1ps
module tb_lag_integrator;

    localparam int ERR_W = 8;
    localparam int ACC_W = 32;
    localparam int EXP_W = 5;
    localparam longint MAXPOS = 64'h7FFF_FFFF;
`ifdef LAG_HIT_COUNT_EN
    localparam bit HITS_ON = 1'b1;
`else
    localparam bit HITS_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             resetN = 1'b1;
    logic             clkEn, clear, hold, sweepEn;
    logic [ERR_W-1:0] error;
    logic [EXP_W-1:0] lagExp;
    logic [ACC_W-1:0] limit, sweepOffsetMag;
    logic [ACC_W-1:0] lagAccum;
    logic [1:0]       sweepState;
    logic             atUpper, atLower;
    logic [15:0]      limitHits;

    always #5 clk = ~clk;

    lag_integrator #(.ERR_W(ERR_W), .ACC_W(ACC_W), .EXP_W(EXP_W)) dut (
        .clk(clk), .resetN(resetN), .clkEn(clkEn), .clear(clear), .hold(hold),
        .error(error), .lagExp(lagExp), .limit(limit), .sweepEn(sweepEn),
        .sweepOffsetMag(sweepOffsetMag), .lagAccum(lagAccum), .sweepState(sweepState),
        .atUpper(atUpper), .atLower(atLower), .limitHits(limitHits)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state: plain integers, state as 0=TRACK 1=UP 2=DOWN
    longint m_acc, m_err, m_off;
    int     m_st, m_hits;
    bit     m_up, m_lo;

    function automatic longint lag_of(logic [7:0] e, logic [4:0] x);
        longint v;
        if (x == 0) return 0;
        v = longint'($signed(e));
        return (v <<< x) >>> (ERR_W - 1);
    endfunction

    task automatic chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        m_acc = 0; m_err = 0; m_off = 0; m_st = 0; m_hits = 0; m_up = 0; m_lo = 0;
    endtask

    always @(posedge clk) begin
        longint sum, ul, nerr;
        bit up, lo;
        if (resetN && clkEn) begin
            if (clear) begin
                model_zero();
            end else begin
                nerr = lag_of(error, lagExp);
                if (!hold) begin
                    sum = m_acc + m_err + m_off;
                    ul  = (longint'(limit) > MAXPOS) ? MAXPOS : longint'(limit);
                    if (ul == 0) begin
                        up = sum > 0;
                        lo = sum < 0;
                    end else begin
                        up = sum >= ul;
                        lo = sum <= -ul;
                    end
                    m_acc = up ? ul : (lo ? -ul : sum);
                    m_up = up;
                    m_lo = lo;
                    if ((up || lo) && m_hits < 65535) m_hits++;
                    if (!sweepEn) begin
                        m_st = 0; m_off = 0;
                    end else if (m_st == 0) begin
                        m_st = 1; m_off = longint'(sweepOffsetMag);
                    end else if (m_st == 1 && up) begin
                        m_st = 2; m_off = -longint'(sweepOffsetMag);
                    end else if (m_st == 2 && lo) begin
                        m_st = 1; m_off = longint'(sweepOffsetMag);
                    end
                end
                m_err = nerr;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model lagAccum", $signed(lagAccum), m_acc);
            chk("model sweepState", sweepState, m_st);
            chk("model atUpper", atUpper, m_up);
            chk("model atLower", atLower, m_lo);
            chk("model limitHits", limitHits, HITS_ON ? m_hits : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        clkEn = 0; clear = 0; hold = 0; sweepEn = 0;
        error = '0; lagExp = '0; limit = '0; sweepOffsetMag = '0;
    endtask

    // Assert reset between edges, check immediately, then let the synchroniser release.
    task automatic do_reset();
        @(posedge clk);
        #2;
        resetN = 1'b0;
        clkEn  = 1'b0;
        model_zero();
        #1;
        chk("reset lagAccum", $signed(lagAccum), 0);
        chk("reset sweepState", sweepState, 0);
        chk("reset flags", {atUpper, atLower}, 0);
        chk("reset limitHits", limitHits, 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        set_idle();
        model_zero();
        do_reset();
        chk_en = 1'b1;

        // Ramp: 1 unit per sample, first nonzero on the second edge
        error = 8'h01; lagExp = 5'd7; limit = 32'h7FFF_FFFF; clkEn = 1;
        tick(); chk("ramp e1", $signed(lagAccum), 0);
        tick(); chk("ramp e2", $signed(lagAccum), 1);
        tick(); chk("ramp e3", $signed(lagAccum), 2);
        tick(); chk("ramp e4", $signed(lagAccum), 3);

        // Most negative error at max exponent clamps low
        set_idle(); do_reset();
        error = 8'h80; lagExp = 5'd31; limit = 32'h100; clkEn = 1;
        tick(); chk("neg e1", $signed(lagAccum), 0);
        tick(); chk("neg clamp", $signed(lagAccum), -256);
        chk("neg atLower", atLower, 1);
        chk("neg limitHits", limitHits, HITS_ON ? 1 : 0);

        // Full-scale positive saturates without wrap
        set_idle(); do_reset();
        error = 8'h7F; lagExp = 5'd31; limit = 32'hFFFF_FFFF; clkEn = 1;
        tick(); tick(); chk("sat e2", $signed(lagAccum), 64'sh7F00_0000);
        tick(); chk("sat e3", $signed(lagAccum), 64'sh7FFF_FFFF);
        chk("sat atUpper", atUpper, 1);
        tick(); chk("sat e4", $signed(lagAccum), 64'sh7FFF_FFFF);

        // Zero limit pins the accumulator at 0
        set_idle(); do_reset();
        error = 8'h01; lagExp = 5'd7; limit = '0; clkEn = 1;
        tick(); chk("lim0 e1 flag", atUpper, 0);
        tick(); chk("lim0 e2", $signed(lagAccum), 0);
        chk("lim0 e2 flag", atUpper, 1);

        // Sweep between +/-0x100 in 0x40 steps
        set_idle(); do_reset();
        sweepEn = 1; sweepOffsetMag = 32'h40; limit = 32'h100; clkEn = 1;
        tick(); chk("sweep enter", sweepState, 1);
        chk("sweep e1", $signed(lagAccum), 0);
        repeat (4) tick();
        chk("sweep top", $signed(lagAccum), 256);
        chk("sweep top state", sweepState, 2);
        repeat (8) tick();
        chk("sweep bottom", $signed(lagAccum), -256);
        chk("sweep bottom state", sweepState, 1);
        repeat (2) tick();
        chk("sweep rising", $signed(lagAccum), -128);
        do_reset();
        clkEn = 1;
        tick(); chk("sweep restart", sweepState, 1);
        tick(); chk("sweep restart acc", $signed(lagAccum), 64);

        // Hold freezes integration; clear beats hold and zeroes stage 1
        set_idle(); do_reset();
        error = 8'h7F; lagExp = 5'd4; limit = 32'h7FFF_FFFF; clkEn = 1;
        repeat (3) tick();
        chk("hold pre", $signed(lagAccum), 30);
        hold = 1; sweepEn = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold acc", $signed(lagAccum), 30);
            chk("hold state", sweepState, 0);
        end
        clear = 1;
        tick(); chk("clear acc", $signed(lagAccum), 0);
        chk("clear state", sweepState, 0);
        clear = 0; hold = 0; sweepEn = 0;
        tick(); chk("clear stage1", $signed(lagAccum), 0);
        tick(); chk("clear resume", $signed(lagAccum), 15);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: limit = $urandom_range(0, 32'h400);
                    1: limit = '0;
                    2: limit = 32'hFFFF_FFFF;
                    default: limit = $urandom;
                endcase
            end
            if (i % 16 == 0)
                sweepOffsetMag = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 32'h200);
            if (i % 50 == 0) sweepEn = ($urandom_range(0, 3) != 0);
            clkEn  = ($urandom_range(0, 9) < 8);
            clear  = ($urandom_range(0, 49) == 0);
            hold   = ($urandom_range(0, 9) == 0);
            error  = ERR_W'($urandom);
            lagExp = ($urandom_range(0, 3) == 0) ? EXP_W'($urandom) : EXP_W'($urandom_range(0, 6));
            if (i % 700 == 350) do_reset();
            tick();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
